// File: rtl/poly_synth_pkg.sv
// Shared types, tuning constants and the note-to-increment helper
// for the polyphonic voice engine.
package poly_synth_pkg;

  localparam int NOTE_W    = 7;
  localparam int ROM_DEPTH = 128;
  localparam int SAMPLE_HZ = 48000;
  localparam int A4_NOTE   = 69;
  localparam int A4_HZ     = 440;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'b00,
    WAVE_SQR = 2'b01,
    WAVE_TRI = 2'b10,
    WAVE_OFF = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    EV_IDLE,
    EV_LOOKUP,
    EV_COMMIT
  } ev_state_e;

  // 2^(k/12) in Q16, k = semitones above A
  function automatic logic [31:0] semi_q16(input int k);
    case (k)
      0:       return 32'd65536;
      1:       return 32'd69433;
      2:       return 32'd73561;
      3:       return 32'd77936;
      4:       return 32'd82570;
      5:       return 32'd87480;
      6:       return 32'd92682;
      7:       return 32'd98193;
      8:       return 32'd104032;
      9:       return 32'd110218;
      10:      return 32'd116772;
      default: return 32'd123715;
    endcase
  endfunction

  function automatic logic [63:0] note_inc(input int note,
                                           input int pw);
    int          d;
    int          oct;
    logic [63:0] num;
    d   = note - A4_NOTE + 120;
    oct = d / 12 - 10;
    num = 64'(A4_HZ) * 64'(semi_q16(d % 12));
    num = num << pw;
    if (oct >= 0) num = num << oct;
    else          num = num >> (-oct);
    return num / (64'(SAMPLE_HZ) << 16);
  endfunction

endpackage

// File: rtl/note_inc_rom.sv
// Note number to phase increment table, one registered read
// per cycle; contents derive from the package tuning constants.
module note_inc_rom
  import poly_synth_pkg::*;
#(
  parameter int PHASE_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NOTE_W-1:0]  addr_i,
  output logic [PHASE_W-1:0] inc_o
);

  logic [PHASE_W-1:0] tbl [ROM_DEPTH];
  logic [PHASE_W-1:0] inc_q;

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_tbl
    assign tbl[g] = PHASE_W'(note_inc(g, PHASE_W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inc_q <= '0;
    else       inc_q <= tbl[addr_i];
  end

  assign inc_o = inc_q;

endmodule

// File: rtl/poly_voice_bank.sv
// Polyphonic voice engine: note event allocation plus a
// one-voice-per-cycle scan that mixes an averaged sample.
module poly_voice_bank
  import poly_synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 20,
  parameter int OUT_W      = 16,
  parameter int AGE_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_note_on,
  input  logic [NOTE_W-1:0]       ev_note,
  input  logic [1:0]              wave_sel,
  input  logic                    sample_tick,
  output logic signed [OUT_W-1:0] mix_out,
  output logic                    mix_valid,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic                    steal_pulse,
  output logic                    overrun
);

  localparam int VI_W  = $clog2(NUM_VOICES);
  localparam int ACC_W = OUT_W + VI_W;

  ev_state_e              state_q;
  logic                   on_q;
  logic [NOTE_W-1:0]      lat_q;
  logic [NUM_VOICES-1:0]  active_q;
  logic [NOTE_W-1:0]      note_q  [NUM_VOICES];
  logic [PHASE_W-1:0]     inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0]     phase_q [NUM_VOICES];
  logic [AGE_W-1:0]       age_q   [NUM_VOICES];
  logic                   steal_q;

  logic                   busy_q;
  logic                   pend_q;
  logic                   ovr_q;
  logic                   mv_q;
  logic [VI_W-1:0]        idx_q;
  logic [ACC_W-1:0]       acc_q;
  logic [OUT_W-1:0]       mix_q;

  logic [PHASE_W-1:0]     rom_inc;
  logic                   scan_idle;
  logic                   ev_acc;
  logic                   scan_go;
  logic [NUM_VOICES-1:0]  hit_d;
  logic [VI_W-1:0]        tgt_d;
  logic                   steal_d;
  logic [OUT_W-1:0]       wv_d;
  logic [ACC_W-1:0]       acc_d;

  function automatic logic [OUT_W-1:0] wave_of(
    input logic [PHASE_W-1:0] ph,
    input logic [1:0]         sel
  );
    logic [OUT_W-1:0] p;
    logic [OUT_W-2:0] t;
    logic             msb;
    p   = ph[PHASE_W-1 -: OUT_W];
    msb = p[OUT_W-1];
    t   = msb ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
    unique case (sel)
      WAVE_SAW: return {~msb, p[OUT_W-2:0]};
      WAVE_SQR: return msb
        ? {1'b1, {(OUT_W-2){1'b0}}, 1'b1}
        : {1'b0, {(OUT_W-1){1'b1}}};
      WAVE_TRI: return {~t[OUT_W-2], t[OUT_W-3:0], 1'b0};
      default:  return '0;
    endcase
  endfunction

  note_inc_rom #(
    .PHASE_W (PHASE_W)
  ) u_rom (
    .clk    (clk),
    .reset  (reset),
    .addr_i (lat_q),
    .inc_o  (rom_inc)
  );

  // A tick seen while an event is in flight is held until
  // the FSM is idle so the table never has two writers.
  assign scan_idle = !busy_q && !pend_q;
  assign ev_ready  = (state_q == EV_IDLE) && scan_idle
                     && !sample_tick;
  assign ev_acc    = ev_valid && ev_ready;
  assign scan_go   = (state_q == EV_IDLE)
                     && (pend_q || (sample_tick && scan_idle));

  always_comb begin
    logic            has_hit;
    logic            has_free;
    logic [VI_W-1:0] hit_i;
    logic [VI_W-1:0] free_i;
    logic [VI_W-1:0] old_i;
    hit_d    = '0;
    has_hit  = 1'b0;
    has_free = 1'b0;
    hit_i    = '0;
    free_i   = '0;
    old_i    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      hit_d[v] = active_q[v] && (note_q[v] == lat_q);
      if (hit_d[v]) begin
        has_hit = 1'b1;
        hit_i   = VI_W'(v);
      end
      if (!active_q[v]) begin
        has_free = 1'b1;
        free_i   = VI_W'(v);
      end
    end
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > age_q[old_i]) old_i = VI_W'(v);
    end
    if (has_hit)       tgt_d = hit_i;
    else if (has_free) tgt_d = free_i;
    else               tgt_d = old_i;
    steal_d = !has_hit && !has_free;
  end

  always_comb begin
    wv_d  = active_q[idx_q]
            ? wave_of(phase_q[idx_q], wave_sel) : '0;
    acc_d = acc_q + {{VI_W{wv_d[OUT_W-1]}}, wv_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EV_IDLE;
      on_q     <= 1'b0;
      lat_q    <= '0;
      active_q <= '0;
      steal_q  <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v]  <= '0;
        inc_q[v]   <= '0;
        phase_q[v] <= '0;
        age_q[v]   <= '0;
      end
    end else begin
      steal_q <= 1'b0;
      unique case (state_q)
        EV_IDLE: begin
          if (ev_acc) begin
            on_q    <= ev_note_on;
            lat_q   <= ev_note;
            state_q <= EV_LOOKUP;
          end
        end
        EV_LOOKUP: state_q <= EV_COMMIT;
        EV_COMMIT: begin
          state_q <= EV_IDLE;
          if (on_q) begin
            steal_q <= steal_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (VI_W'(v) == tgt_d) begin
                active_q[v] <= 1'b1;
                note_q[v]   <= lat_q;
                inc_q[v]    <= rom_inc;
                phase_q[v]  <= '0;
                age_q[v]    <= '0;
              end else if (active_q[v] && age_q[v] != '1) begin
                age_q[v] <= age_q[v] + 1'b1;
              end
            end
          end else begin
            active_q <= active_q & ~hit_d;
          end
        end
        default: state_q <= EV_IDLE;
      endcase
      if (busy_q && active_q[idx_q])
        phase_q[idx_q] <= phase_q[idx_q] + inc_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      mv_q   <= 1'b0;
      idx_q  <= '0;
      acc_q  <= '0;
      mix_q  <= '0;
    end else begin
      mv_q <= 1'b0;
      if (sample_tick && !scan_idle) ovr_q <= 1'b1;
      if (sample_tick && scan_idle && state_q != EV_IDLE)
        pend_q <= 1'b1;
      if (scan_go) begin
        pend_q <= 1'b0;
        busy_q <= 1'b1;
        idx_q  <= '0;
        acc_q  <= '0;
      end else if (busy_q) begin
        acc_q <= acc_d;
        idx_q <= idx_q + 1'b1;
        if (idx_q == VI_W'(NUM_VOICES - 1)) begin
          busy_q <= 1'b0;
          mix_q  <= acc_d[ACC_W-1:VI_W];
          mv_q   <= 1'b1;
        end
      end
    end
  end

  assign mix_out      = mix_q;
  assign mix_valid    = mv_q;
  assign voice_active = active_q;
  assign steal_pulse  = steal_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_poly_voice_bank.sv
// Self-checking bench for poly_voice_bank: event vector table
// plus a mix scoreboard fed on every tick.
module tb_poly_voice_bank;

  localparam int A4_INC = 9611;
  localparam int PH_MSK = 20'hFFFFF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ev_valid = 1'b0;
  logic              ev_note_on = 1'b0;
  logic [6:0]        ev_note = '0;
  logic [1:0]        wave_sel = '0;
  logic              sample_tick = 1'b0;
  logic              ev_ready;
  logic signed [15:0] mix_out;
  logic              mix_valid;
  logic [7:0]        voice_active;
  logic              steal_pulse;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_q[$];

  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [7:0] act;
    logic       steal;
  } ev_vec_t;

  ev_vec_t    vecs[13];
  logic [1:0] sels[5];

  poly_voice_bank dut (
    .clk          (clk),
    .reset        (reset),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note_on   (ev_note_on),
    .ev_note      (ev_note),
    .wave_sel     (wave_sel),
    .sample_tick  (sample_tick),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .voice_active (voice_active),
    .steal_pulse  (steal_pulse),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int mix1(input int ph, input int sel);
    int p;
    int w;
    p = (ph >> 4) & 16'hFFFF;
    case (sel)
      0:       w = p - 32768;
      1:       w = (p < 32768) ? 32767 : -32767;
      2:       w = 2 * ((p < 32768) ? p : 65535 - p) - 32768;
      default: w = 0;
    endcase
    return w >>> 3;
  endfunction

  always @(negedge clk) begin
    int e;
    if (!reset && mix_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mix: got %0d, expected none",
                 mix_out);
      end else begin
        e = exp_q.pop_front();
        chk("mix_out", int'(mix_out), e);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_ev(input logic on, input logic [6:0] n);
    int w;
    w = 0;
    while (!ev_ready && w < 50) begin
      @(posedge clk);
      #1 w++;
    end
    if (!ev_ready) begin
      checks++;
      errors++;
      $display("FAIL ev_ready_timeout: got 0, expected 1");
    end
    ev_valid   = 1'b1;
    ev_note_on = on;
    ev_note    = n;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 40) begin
      @(posedge clk);
      #1 w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL mix_timeout: got %0d pending, expected 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int ph;
    int p0;
    vecs[0]  = '{1'b1, 7'd60, 8'h01, 1'b0};
    vecs[1]  = '{1'b1, 7'd61, 8'h03, 1'b0};
    vecs[2]  = '{1'b1, 7'd62, 8'h07, 1'b0};
    vecs[3]  = '{1'b1, 7'd63, 8'h0F, 1'b0};
    vecs[4]  = '{1'b1, 7'd64, 8'h1F, 1'b0};
    vecs[5]  = '{1'b1, 7'd65, 8'h3F, 1'b0};
    vecs[6]  = '{1'b1, 7'd66, 8'h7F, 1'b0};
    vecs[7]  = '{1'b1, 7'd67, 8'hFF, 1'b0};
    vecs[8]  = '{1'b1, 7'd68, 8'hFF, 1'b1};
    vecs[9]  = '{1'b0, 7'd72, 8'hFF, 1'b0};
    vecs[10] = '{1'b0, 7'd61, 8'hFD, 1'b0};
    vecs[11] = '{1'b1, 7'd70, 8'hFF, 1'b0};
    vecs[12] = '{1'b0, 7'd68, 8'hFE, 1'b0};
    sels = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1};

    do_reset();
    chk("rst_mix_out", int'(mix_out), 0);
    chk("rst_mix_valid", int'(mix_valid), 0);
    chk("rst_voice_active", int'(voice_active), 0);
    chk("rst_steal", int'(steal_pulse), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ev_ready", int'(ev_ready), 1);

    sample_tick = 1'b1;
    #1 chk("tick_priority_ready", int'(ev_ready), 0);
    exp_q.push_back(0);
    @(posedge clk);
    #1 sample_tick = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("mix_valid_t8", int'(mix_valid), 0);
    @(posedge clk);
    #1 chk("mix_valid_t9", int'(mix_valid), 1);
    chk("ready_after_scan", int'(ev_ready), 1);
    drain();

    wave_sel = 2'd1;
    send_ev(1'b1, 7'd69);
    chk("a4_active", int'(voice_active), 1);
    ph = 0;
    for (int s = 0; s < 5; s++) begin
      wave_sel = sels[s];
      exp_q.push_back(mix1(ph, int'(sels[s])));
      pulse_tick();
      drain();
      ph = (ph + A4_INC) & PH_MSK;
    end

    do_reset();
    for (int i = 0; i < 13; i++) begin
      send_ev(vecs[i].on, vecs[i].note);
      chk($sformatf("vec%0d_active", i),
          int'(voice_active), int'(vecs[i].act));
      chk($sformatf("vec%0d_steal", i),
          int'(steal_pulse), int'(vecs[i].steal));
    end

    do_reset();
    wave_sel = 2'd0;
    send_ev(1'b1, 7'd60);
    chk("retrig_first", int'(voice_active), 1);
    exp_q.push_back(mix1(0, 0));
    pulse_tick();
    drain();
    send_ev(1'b1, 7'd60);
    chk("retrig_active", int'(voice_active), 1);
    chk("retrig_steal", int'(steal_pulse), 0);
    exp_q.push_back(mix1(0, 0));
    pulse_tick();
    drain();
    send_ev(1'b0, 7'd72);
    chk("off_nomatch", int'(voice_active), 1);
    send_ev(1'b1, 7'd62);
    chk("second_voice", int'(voice_active), 3);
    send_ev(1'b0, 7'd60);
    chk("off_60", int'(voice_active), 2);

    do_reset();
    wave_sel = 2'd1;
    send_ev(1'b1, 7'd69);
    exp_q.push_back(mix1(0, 1));
    pulse_tick();
    drain();
    ph = A4_INC;
    p0 = pulses;
    exp_q.push_back(mix1(ph, 1));
    pulse_tick();
    repeat (2) @(posedge clk);
    #1 pulse_tick();
    drain();
    repeat (3) @(posedge clk);
    #1 chk("overrun_set", int'(overrun), 1);
    chk("overrun_one_pulse", pulses - p0, 1);
    ph = (ph + A4_INC) & PH_MSK;
    exp_q.push_back(mix1(ph, 1));
    pulse_tick();
    drain();
    chk("overrun_sticky", int'(overrun), 1);

    p0 = pulses;
    pulse_tick();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    chk("midrst_mix_out", int'(mix_out), 0);
    chk("midrst_mix_valid", int'(mix_valid), 0);
    chk("midrst_active", int'(voice_active), 0);
    chk("midrst_steal", int'(steal_pulse), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_ev_ready", int'(ev_ready), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1 chk("midrst_no_pulse", pulses - p0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
